// File: rtl/pulse_period_meter.sv
// Measures clk cycles between successive rising edges of pulse_in and reports each period on a valid/ready output.
// Optional PERIOD_AVG_EN: report the mean of every 4 consecutive captured periods instead.
module pulse_period_meter #(
    parameter int CNT_W       = 30,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t               state, next_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 hist_q;
    logic                 det;
    logic                 capture;
    logic [CNT_W-1:0]     cnt;
    logic                 sat;
    logic [CNT_W-1:0]     res_val;
    logic                 res_ovf;
    logic                 res_fire;
    logic                 load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign det = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign sat = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            IDLE: if (enable) next_state = ARM;
            ARM: begin
                if (!enable)  next_state = IDLE;
                else if (det) next_state = MEAS;
            end
            MEAS: begin
                if (!enable)  next_state = IDLE;
                else if (det) capture = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Disable discards any partial count; an edge in ARM or MEAS restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        cnt <= '0;
        else if (!enable || state == IDLE) cnt <= '0;
        else if (det)                      cnt <= CNT_W'(1);
        else if (state == MEAS && !sat)    cnt <= cnt + CNT_W'(1);
    end

`ifdef PERIOD_AVG_EN
    logic [CNT_W+1:0] acc;
    logic [CNT_W+1:0] sum;
    logic [1:0]       grp_cnt;
    logic             grp_ovf;

    assign sum      = acc + {2'b00, cnt};
    assign res_val  = sum[CNT_W+1:2];
    assign res_ovf  = grp_ovf | sat;
    assign res_fire = capture && (grp_cnt == 2'd3);

    // A completed group clears whether its result loaded or was dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            grp_cnt <= '0;
            grp_ovf <= 1'b0;
        end else if (!enable || state == IDLE || res_fire) begin
            acc     <= '0;
            grp_cnt <= '0;
            grp_ovf <= 1'b0;
        end else if (capture) begin
            acc     <= sum;
            grp_cnt <= grp_cnt + 2'd1;
            grp_ovf <= res_ovf;
        end
    end
`else
    assign res_val  = cnt;
    assign res_ovf  = sat;
    assign res_fire = capture;
`endif

    assign load = res_fire && (!period_valid || period_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_out   <= '0;
            overflow     <= 1'b0;
            period_valid <= 1'b0;
        end else if (load) begin
            period_out   <= res_val;
            overflow     <= res_ovf;
            period_valid <= 1'b1;
        end else if (period_valid && period_ready) begin
            period_valid <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter (CNT_W=4 so saturation is reachable quickly).
module tb_pulse_period_meter;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             pulse_in;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             period_ready;
    logic             overflow;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CNT_W-1:0] p;
        logic             o;
    } res_t;

    typedef struct {
        int               gap;
        int               npulses;
        int               exp_n;
        logic [CNT_W-1:0] exp_p;
    } vec_t;

    res_t got[$];
    res_t exp_q[$];
    vec_t vecs[4];

    pulse_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .pulse_in     (pulse_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Record every accepted transfer.
    always @(negedge clk)
        if (rst_n && period_valid && period_ready)
            got.push_back('{period_out, overflow});

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_gap(input int gap);
        pulse_in = 1'b1;
        tick(1);
        pulse_in = 1'b0;
        tick(gap - 1);
    endtask

    task automatic train(input int gap, input int n);
        repeat (n) pulse_gap(gap);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_results(input string name);
        chk({name, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                chk($sformatf("%s[%0d] period", name, i), 32'(got[i].p), 32'(exp_q[i].p));
                chk($sformatf("%s[%0d] overflow", name, i), 32'(got[i].o), 32'(exp_q[i].o));
            end
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, " period_valid"}, 32'(period_valid), 0);
        chk({name, " period_out"}, 32'(period_out), 0);
        chk({name, " overflow"}, 32'(overflow), 0);
        chk({name, " busy"}, 32'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{gap: 10, npulses: 5, exp_n: 4, exp_p: 4'd10};
        vecs[1] = '{gap: 6,  npulses: 3, exp_n: 2, exp_p: 4'd6};
        vecs[2] = '{gap: 2,  npulses: 4, exp_n: 3, exp_p: 4'd2};
        vecs[3] = '{gap: 14, npulses: 2, exp_n: 1, exp_p: 4'd14};

        rst_n = 1'b0; enable = 1'b0; pulse_in = 1'b0; period_ready = 1'b0;
        tick(3);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        train(5, 4);
        chk("disabled period_valid", 32'(period_valid), 0);
        chk("disabled busy", 32'(busy), 0);

`ifdef PERIOD_AVG_EN
        enable = 1'b1; period_ready = 1'b1;
        tick(2);
        got.delete();
        pulse_gap(8); pulse_gap(9); pulse_gap(10); pulse_gap(12); pulse_gap(3);
        tick(6); enable = 1'b0; tick(4);
        exp_q = '{'{4'd9, 1'b0}};
        chk_results("avg group");

        enable = 1'b1;
        tick(2);
        got.delete();
        train(13, 3);
        enable = 1'b0; tick(2); enable = 1'b1; tick(1);
        train(8, 5);
        tick(6); enable = 1'b0; tick(4);
        exp_q = '{'{4'd8, 1'b0}};
        chk_results("avg abort");
`else
        // First result timing relative to the second rise.
        enable = 1'b1; period_ready = 1'b1;
        tick(2);
        got.delete();
        pulse_gap(10);
        pulse_in = 1'b1; tick(1); pulse_in = 1'b0;
        tick(1);
        chk("latency edge2 valid", 32'(period_valid), 0);
        tick(1);
        chk("latency edge3 valid", 32'(period_valid), 1);
        chk("latency edge3 period", 32'(period_out), 10);
        tick(7);
        train(10, 3);
        tick(8); enable = 1'b0; tick(4);
        exp_q = '{'{4'd10, 1'b0}, '{4'd10, 1'b0}, '{4'd10, 1'b0}, '{4'd10, 1'b0}};
        chk_results("basic");

        for (int v = 0; v < 4; v++) begin
            enable = 1'b1; period_ready = 1'b1;
            tick(2);
            got.delete();
            train(vecs[v].gap, vecs[v].npulses);
            tick(8); enable = 1'b0; tick(4);
            exp_q.delete();
            for (int k = 0; k < vecs[v].exp_n; k++) exp_q.push_back('{vecs[v].exp_p, 1'b0});
            chk_results($sformatf("vec%0d", v));
        end

        // Backpressure: first 7 held, later captures dropped.
        enable = 1'b1; period_ready = 1'b0;
        tick(2);
        got.delete();
        train(7, 4);
        chk("bp hold valid", 32'(period_valid), 1);
        chk("bp hold period", 32'(period_out), 7);
        pulse_in = 1'b1; tick(1); pulse_in = 1'b0; tick(3);
        chk("bp hold2 period", 32'(period_out), 7);
        period_ready = 1'b1;
        tick(8);
        train(12, 3);
        tick(8); enable = 1'b0; tick(4);
        exp_q = '{'{4'd7, 1'b0}, '{4'd12, 1'b0}, '{4'd12, 1'b0}, '{4'd12, 1'b0}};
        chk_results("backpressure");

        // Saturation then a short period.
        enable = 1'b1; period_ready = 1'b1;
        tick(2);
        got.delete();
        pulse_gap(40); pulse_gap(5); pulse_gap(3);
        tick(6); enable = 1'b0; tick(4);
        exp_q = '{'{4'd15, 1'b1}, '{4'd5, 1'b0}};
        chk_results("saturation");

        // Enable dropped mid-measurement discards the partial interval.
        enable = 1'b1;
        tick(2);
        got.delete();
        pulse_in = 1'b1; tick(1); pulse_in = 1'b0; tick(4);
        enable = 1'b0; tick(2); enable = 1'b1; tick(1);
        train(8, 3);
        tick(6); enable = 1'b0; tick(4);
        exp_q = '{'{4'd8, 1'b0}, '{4'd8, 1'b0}};
        chk_results("enable abort");

        // Async reset with a pending result, then a fresh first edge is required.
        enable = 1'b1; period_ready = 1'b0;
        tick(2);
        train(9, 2);
        chk("pre-reset valid", 32'(period_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrun reset");
        tick(2);
        rst_n = 1'b1; period_ready = 1'b1;
        got.delete();
        tick(1);
        pulse_gap(9); pulse_gap(9);
        tick(6); enable = 1'b0; tick(4);
        exp_q = '{'{4'd9, 1'b0}};
        chk_results("after reset");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
